keypad_scanner: RTL and testbench

Scans a 4x4 matrix keypad and produces debounced hexadecimal key codes for the 7-segment display path on the iCE40 board. This is the input-side counterpart of the hex-to-segment encoder. It drives one active-low column at a time and samples the active-low rows. After a debounce interval it emits a one-cycle valid pulse with a 4-bit code. It runs on the HSOSC-derived clock, 48 MHz nominal.

---
 rtl/keypad_pkg.sv | 65 ++++++
 rtl/row_sync.sv | 35 +++
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - state_t          : scanner FSM states
//   - DEFAULT_*        : default timing constants for a 48 MHz clock
//   - key_code()       : (row, col) -> hex code lookup for the keypad legend
//   - lowest_low_row() : priority pick of the lowest-index active-low row
//   - col_drive()      : column index -> active-low one-hot column drive
// -----------------------------------------------------------------------------
package keypad_pkg;

    // 0.5 ms column dwell and 20 ms debounce at 48 MHz.
    localparam int DEFAULT_SCAN_DIV        = 24000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 960000;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Keypad legend, rows top to bottom, columns left to right:
    //   r0: 1 2 3 A
    //   r1: 4 5 6 B
    //   r2: 7 8 9 C
    //   r3: E 0 F D
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Several keys in one column: the lowest row index wins.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0])      idx = 2'd0;
        else if (!r[1]) idx = 2'd1;
        else if (!r[2]) idx = 2'd2;
        else            idx = 2'd3;
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/row_sync.sv
// -----------------------------------------------------------------------------
// row_sync
// Two-flop synchronizer for the asynchronous keypad row inputs.
// Ports:
//   clk    in          system clock
//   reset  in          asynchronous, active-high reset
//   d      in  [W-1:0] asynchronous input
//   q      out [W-1:0] synchronized output, two cycles of latency
// -----------------------------------------------------------------------------
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Reset to all ones, the idle level of the pulled-up rows, so coming out
    // of reset never looks like a key press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            // NOTE: non-blocking assignments make q take the previous value of
            // meta, giving two real flop stages instead of one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad one column at a time, debounces a
// detected key and reports its hex code.
// Ports:
//   clk        in      system clock (HSOSC, 48 MHz nominal)
//   reset      in      asynchronous, active-high reset
//   rows       in  [4] row sense, active-low, asynchronous to clk
//   cols       out [4] column drive, active-low one-hot
//   key        out [4] hex code of the last accepted key
//   key_valid  out     one-cycle pulse when a new key is accepted
//   key_held   out     high while the accepted key remains pressed
// Parameters (each must be at least 2):
//   SCAN_DIV         cycles each column is driven before moving on
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a press or release
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]     rs;
    state_t         state;
    logic [1:0]     col_idx;
    logic [1:0]     row_idx;
    logic [DW-1:0]  dwell_cnt;
    logic [DBW-1:0] deb_cnt;

    logic [1:0] col_next;
    logic       row_low;

    row_sync #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rs)
    );

    assign col_next = col_idx + 2'd1;
    assign row_low  = ~rs[row_idx];

    // cols is kept as its own flop, updated in step with col_idx, so the pad
    // drive never glitches through a decoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            cols      <= 4'b1110;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;

            unique case (state)
                SCAN: begin
                    // Rows are sampled only on the last dwell cycle so the
                    // synchronized value reflects the current column.
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (rs != 4'hF) begin
                            // Stay on this column while the press is debounced.
                            row_idx <= lowest_low_row(rs);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_next;
                            cols    <= col_drive(col_next);
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (row_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            key       <= key_code(row_idx, col_idx);
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= HELD;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: give up on this key and carry on scanning.
                        col_idx   <= col_next;
                        cols      <= col_drive(col_next);
                        dwell_cnt <= '0;
                        state     <= SCAN;
                    end
                end

                HELD: begin
                    // Only the captured row matters; other keys are ignored.
                    if (!row_low) begin
                        deb_cnt <= '0;
                        state   <= RELEASE;
                    end
                end

                RELEASE: begin
                    if (!row_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_held  <= 1'b0;
                            col_idx   <= col_next;
                            cols      <= col_drive(col_next);
                            dwell_cnt <= '0;
                            state     <= SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        // Release bounce: still held, no new key_valid.
                        state <= HELD;
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
// Drives a simulated physical keypad (a 16-bit "pressed" matrix wired between
// the DUT column drive and row sense) and compares the DUT outputs every cycle
// against a behavioural model built from run lengths and scan time.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;

    bit         clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    // pressed[r*4+c] = key at row r, column c is physically down.
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical matrix: a row is pulled low when a pressed key on it sits in a
    // column that is currently being driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    logic [3:0] key_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};

    // ---------------- reference model ----------------
    logic [3:0] m_s1, m_s2;
    int         scan_ticks, base_col, lock_row, lock_col, run;
    bit         m_locked, m_accepted;
    logic [3:0] m_key, m_cols;
    logic       m_valid, m_held;

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        scan_ticks = 0; base_col = 0; lock_row = 0; lock_col = 0; run = 0;
        m_locked = 1'b0; m_accepted = 1'b0;
        m_key = 4'h0; m_valid = 1'b0; m_held = 1'b0; m_cols = 4'b1110;
    endtask

    // One clock of the model. rs is what the rows looked like two edges ago.
    // Press accepted after DEB consecutive low cycles following the sample;
    // release accepted after DEB+1 consecutive high cycles while held.
    task automatic model_step();
        logic [3:0] rs;
        int col;
        rs   = m_s2;
        m_s2 = m_s1;
        m_s1 = rows;
        m_valid = 1'b0;
        if (!m_locked) begin
            col = (base_col + scan_ticks / SCAN_DIV) % 4;
            if ((scan_ticks % SCAN_DIV) == SCAN_DIV - 1 && rs != 4'hF) begin
                m_locked = 1'b1;
                lock_col = col;
                run      = 0;
                lock_row = -1;
                for (int r = 3; r >= 0; r--) if (!rs[r]) lock_row = r;
            end
            scan_ticks++;
        end else if (!m_accepted) begin
            if (!rs[lock_row]) begin
                run++;
                if (run == DEB) begin
                    m_accepted = 1'b1;
                    m_key      = key_map[lock_row*4 + lock_col];
                    m_valid    = 1'b1;
                    m_held     = 1'b1;
                    run        = 0;
                end
            end else begin
                m_locked   = 1'b0;
                base_col   = (lock_col + 1) % 4;
                scan_ticks = 0;
            end
        end else begin
            if (rs[lock_row]) begin
                run++;
                if (run == DEB + 1) begin
                    m_accepted = 1'b0;
                    m_locked   = 1'b0;
                    m_held     = 1'b0;
                    base_col   = (lock_col + 1) % 4;
                    scan_ticks = 0;
                end
            end else begin
                run = 0;
            end
        end
        col = m_locked ? lock_col : (base_col + scan_ticks / SCAN_DIV) % 4;
        m_cols = ~(4'b0001 << col);
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("cols",      int'(cols),      int'(m_cols));
            check("key",       int'(key),       int'(m_key));
            check("key_valid", int'(key_valid), int'(m_valid));
            check("key_held",  int'(key_held),  int'(m_held));
            if (key_valid) pulses++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic bit cond_met(input int which);
        case (which)
            0:       return m_locked;
            1:       return !m_locked;
            2:       return m_accepted;
            default: return m_accepted && run == 4;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int budget);
        int n = 0;
        while (!cond_met(which) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(cond_met(which)), 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int p0;
        logic [15:0] keep;

        // Reset state
        cycles(3);
        #1;
        check("rst_cols",      int'(cols),      4'hE);
        check("rst_key",       int'(key),       0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held",  int'(key_held),  0);
        @(negedge clk);
        reset = 1'b0;

        // Idle scan: the per-cycle checker follows the column rotation.
        cycles(20);

        // Clean press of row1/col2 ('6') and clean release.
        p0 = pulses;
        pressed = 16'h1 << (1*4 + 2);
        wait_for("s2_accept", 2, 200);
        cycles(10);
        #1;
        check("s2_key",  int'(key), 6);
        check("s2_held", int'(key_held), 1);
        pressed = '0;
        wait_for("s2_unlock", 1, 100);
        check("s2_resume_cols", int'(cols), 4'b0111);
        #1;
        check("s2_pulses", pulses - p0, 1);

        // Press bounce: row low only a few cycles after detection.
        p0 = pulses;
        pressed = 16'h1 << (1*4 + 2);
        wait_for("s3_lock", 0, 100);
        cycles(3);
        pressed = '0;
        wait_for("s3_unlock", 1, 50);
        check("s3_resume_cols", int'(cols), 4'b0111);
        #1;
        check("s3_pulses", pulses - p0, 0);
        check("s3_key",    int'(key), 6);

        // Release bounce: one low cycle arrives at release counter 5.
        p0 = pulses;
        pressed = 16'h1 << (2*4 + 1);
        wait_for("s4_accept", 2, 200);
        cycles(5);
        pressed = '0;
        wait_for("s4_run", 3, 100);
        pressed = 16'h1 << (2*4 + 1);
        cycles(1);
        pressed = '0;
        wait_for("s4_unlock", 1, 100);
        #1;
        check("s4_pulses", pulses - p0, 1);
        check("s4_key",    int'(key), 8);
        check("s4_held",   int'(key_held), 0);

        // Rows 0 and 3 both low in column 0: lowest row wins.
        p0 = pulses;
        pressed = 16'h1 | (16'h1 << 12);
        wait_for("s5_accept", 2, 200);
        #1;
        check("s5_key", int'(key), 1);
        pressed = '0;
        wait_for("s5_unlock", 1, 100);
        #1;
        check("s5_pulses", pulses - p0, 1);

        // Asynchronous reset while held.
        pressed = 16'h1 << 3;
        wait_for("s6_accept", 2, 200);
        cycles(3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cols",      int'(cols),      4'hE);
        check("arst_key",       int'(key),       0);
        check("arst_key_valid", int'(key_valid), 0);
        check("arst_key_held",  int'(key_held),  0);
        pressed = '0;
        @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
        cycles(30);
        #1;
        check("s6_pulses", pulses - p0, 0);
        check("s6_key",    int'(key), 0);

        // Randomized presses, multi-key patterns and bounces.
        for (int it = 0; it < 60; it++) begin
            pressed = '0;
            repeat ($urandom_range(1, 2)) pressed[$urandom_range(0, 15)] = 1'b1;
            cycles($urandom_range(5, 80));
            if ($urandom_range(0, 3) == 0) begin
                keep = pressed;
                pressed = '0;
                cycles($urandom_range(1, 3));
                pressed = keep;
                cycles($urandom_range(1, 20));
            end
            pressed = '0;
            cycles($urandom_range(0, 40));
        end
        cycles(60);
        #1;
        check("final_held", int'(key_held), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
